// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with break detection
// Ports: clk/resetn (sync, active-low); uart_rxd serial input; uart_rx_en
//        enables start-bit detection; uart_rx_valid pulses for one cycle with
//        uart_rx_data; uart_rx_break pulses when a frame of zeros has a low stop bit.

module uart_rx #(
    parameter int CLK_HZ       = 1_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
    localparam int CPB  = (CLK_HZ / BIT_RATE < 2) ? 2 : CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(PAYLOAD_BITS + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t               state_q, state_d;
    logic [2:0]              sync_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    brk_q, brk_d;
    logic                    rxd;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value.
    assign rxd = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        brk_d   = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                // A start needs a high-to-low edge, so a line held low after
                // a break does not retrigger.
                if (uart_rx_en && sync_q[2] && !rxd) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d  = '0;
                    data_d = {rxd, data_q[PAYLOAD_BITS-1:1]};
                    bit_d  = bit_q + BW'(1);
                    if (bit_q == BW'(PAYLOAD_BITS - 1)) state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    state_d = R_IDLE;
                    valid_d = rxd;
                    brk_d   = !rxd && (data_q == '0);
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= R_IDLE;
            sync_q  <= 3'b111;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], uart_rxd};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            brk_q   <= brk_d;
        end
    end

    assign uart_rx_valid = valid_q;
    assign uart_rx_break = brk_q;
    assign uart_rx_data  = data_q;
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter
// Ports: clk/resetn (sync, active-low); uart_tx_en loads uart_tx_data when idle;
//        uart_tx_busy high while a frame is on the line; uart_txd serial output.

module uart_tx #(
    parameter int CLK_HZ       = 1_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
    localparam int CPB = (CLK_HZ / BIT_RATE < 2) ? 2 : CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int FW  = PAYLOAD_BITS + 2;
    localparam int NW  = $clog2(FW + 1);

    logic [FW-1:0] shift_q, shift_d;
    logic [NW-1:0] left_q, left_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        if (left_q == '0) begin
            if (uart_tx_en) begin
                shift_d = {1'b1, uart_tx_data, 1'b0};
                left_d  = NW'(FW);
                cnt_d   = '0;
            end
        end else if (cnt_q == CW'(CPB - 1)) begin
            cnt_d   = '0;
            shift_d = {1'b1, shift_q[FW-1:1]};
            left_d  = left_q - NW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_q <= '1;
            left_q  <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
        end
    end

    assign uart_tx_busy = (left_q != '0);
    assign uart_txd     = uart_tx_busy ? shift_q[0] : 1'b1;
endmodule

// File: rtl/gs_uart_fifo.sv
// rtl/gs_uart_fifo.sv - UART with CPU register port, RX/TX FIFOs and interrupt
// Ports: clk/resetn (sync, active-low); ADDR/CS/WE/DI CPU access (00 data,
//        01 status, 10 control, 11 RX level); DO combinational read data;
//        IRQ level interrupt; uart_rxd/uart_txd serial pins.

module gs_uart_fifo #(
    parameter int CLK_HZ   = 1_000_000,
    parameter int BIT_RATE = 115200,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] ADDR,
    input  logic       CS,
    input  logic       WE,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       IRQ,
    input  logic       uart_rxd,
    output logic       uart_txd
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_LW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_LW = TX_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAITB, S_DRAIN} tx_state_t;

    logic       rx_valid, rx_break;
    logic [7:0] rx_data;
    logic       tx_busy, tx_en;
    logic [7:0] tx_head;

    uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8)) u_rx (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rxd      (uart_rxd),
        .uart_rx_en    (1'b1),
        .uart_rx_break (rx_break),
        .uart_rx_valid (rx_valid),
        .uart_rx_data  (rx_data)
    );

    uart_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8)) u_tx (
        .clk          (clk),
        .resetn       (resetn),
        .uart_txd     (uart_txd),
        .uart_tx_busy (tx_busy),
        .uart_tx_en   (tx_en),
        .uart_tx_data (tx_head)
    );

    // An access acts once: a strobe repeating the previous cycle's kind and
    // address is the same access still being held.
    logic       rd_q, wr_q;
    logic [1:0] addr_q;
    logic       rd_first, wr_first;
    logic       data_rd, stat_rd, data_wr, ctrl_wr;

    assign rd_first = CS & ~WE & ~(rd_q & (addr_q == ADDR));
    assign wr_first = CS & WE & ~(wr_q & (addr_q == ADDR));
    assign data_rd  = rd_first & (ADDR == 2'b00);
    assign stat_rd  = rd_first & (ADDR == 2'b01);
    assign data_wr  = wr_first & (ADDR == 2'b00);
    assign ctrl_wr  = wr_first & (ADDR == 2'b10);

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_LW-1:0] rx_level_q, rx_level_d;
    logic             rx_empty, rx_full, rx_pop, rx_push, rx_flush;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_LW-1:0] tx_level_q, tx_level_d;
    logic             tx_empty, tx_full, tx_pop, tx_push, tx_flush;

    logic       brk_q, brk_d, ovr_q, ovr_d;
    logic [2:0] ctrl_q, ctrl_d;
    tx_state_t  state_q, state_d;
    logic       tx_active;
    logic [7:0] status;
    logic [15:0] rx_level_w;
    logic       unused_ok;

    assign rx_empty = (rx_level_q == '0);
    assign rx_full  = (rx_level_q == RX_LW'(RX_DEPTH));
    assign rx_pop   = data_rd & ~rx_empty;
    assign rx_push  = rx_valid & (~rx_full | rx_pop);
    assign rx_flush = ctrl_wr & DI[6];

    assign tx_empty = (tx_level_q == '0);
    assign tx_full  = (tx_level_q == TX_LW'(TX_DEPTH));
    assign tx_push  = data_wr & ~tx_full;
    assign tx_flush = ctrl_wr & DI[7];
    assign tx_head  = tx_mem[tx_rptr_q];

    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_level_d = rx_level_q;
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_level_d = tx_level_q;
        ctrl_d     = ctrl_q;

        if (rx_push) rx_wptr_d = rx_wptr_q + RX_AW'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_AW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_level_d = rx_level_q + RX_LW'(1);
            2'b01:   rx_level_d = rx_level_q - RX_LW'(1);
            default: rx_level_d = rx_level_q;
        endcase

        if (tx_push) tx_wptr_d = tx_wptr_q + TX_AW'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_AW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + TX_LW'(1);
            2'b01:   tx_level_d = tx_level_q - TX_LW'(1);
            default: tx_level_d = tx_level_q;
        endcase

        // Sticky flags: a set in the same cycle as the clearing status read wins.
        brk_d = rx_break | (brk_q & ~stat_rd);
        ovr_d = (rx_valid & rx_full & ~rx_pop) | (ovr_q & ~stat_rd);

        if (ctrl_wr) ctrl_d = DI[2:0];
        if (rx_flush) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_level_d = '0;
            ovr_d      = 1'b0;
        end
        if (tx_flush) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_level_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_en   = 1'b0;
        tx_pop  = 1'b0;
        case (state_q)
            S_IDLE:   if (!tx_empty && !tx_busy) state_d = S_LAUNCH;
            S_LAUNCH: begin
                // A flush landing on the decision cycle leaves nothing to send.
                if (tx_empty) begin
                    state_d = S_IDLE;
                end else begin
                    tx_en   = 1'b1;
                    tx_pop  = 1'b1;
                    state_d = S_WAITB;
                end
            end
            S_WAITB:  if (tx_busy) state_d = S_DRAIN;
            S_DRAIN:  if (!tx_busy) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 2'b00;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ctrl_q     <= 3'b101;
            state_q    <= S_IDLE;
        end else begin
            rd_q       <= CS & ~WE;
            wr_q       <= CS & WE;
            addr_q     <= ADDR;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_level_q <= rx_level_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_level_q <= tx_level_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
            ctrl_q     <= ctrl_d;
            state_q    <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= DI;
    end

    assign tx_active  = (state_q != S_IDLE) | tx_busy;
    assign IRQ        = (ctrl_q[0] & (~rx_empty | ovr_q))
                      | (ctrl_q[1] & tx_empty & (state_q == S_IDLE) & ~tx_busy)
                      | (ctrl_q[2] & brk_q);
    assign status     = {IRQ, tx_empty, rx_full, ovr_q, ~rx_empty, tx_active, brk_q, tx_full};
    assign rx_level_w = 16'(rx_level_q);
    assign unused_ok  = &{1'b0, DI[5:3]};

    always_comb begin
        DO = 8'h00;
        case (ADDR)
            2'b00:   DO = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
            2'b01:   DO = status;
            2'b10:   DO = {5'b00000, ctrl_q};
            default: DO = (rx_level_w > 16'd255) ? 8'hFF : rx_level_w[7:0];
        endcase
    end
endmodule

// File: tb/tb_gs_uart_fifo.sv
// tb/tb_gs_uart_fifo.sv - self-checking bench for gs_uart_fifo
`timescale 1ns/1ps

module tb_gs_uart_fifo;
    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 100_000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] ADDR;
    logic       CS, WE;
    logic [7:0] DI, DO;
    logic       IRQ;
    logic       uart_rxd;
    logic       uart_txd;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_got[$];
    logic [7:0] txb[$];
    bit         rx_ovr;
    bit         mon_en = 1'b0;
    logic [7:0] d, s, mb, exp_b;
    int         n;

    gs_uart_fifo #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .ADDR(ADDR), .CS(CS), .WE(WE), .DI(DI),
        .DO(DO), .IRQ(IRQ), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        @(negedge clk);
        CS = 1'b1; WE = 1'b0; ADDR = a;
        #1 v = DO;
        @(negedge clk);
        CS = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        CS = 1'b1; WE = 1'b1; ADDR = a; DI = v;
        @(negedge clk);
        CS = 1'b0; WE = 1'b0;
    endtask

    // Serial frame into the DUT; the model keeps what a DEPTH-entry FIFO keeps.
    task automatic send_byte(input logic [7:0] b);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        repeat (3) @(negedge clk);
        if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
        else rx_ovr = 1'b1;
    endtask

    // Decodes frames seen on uart_txd, sampling mid-bit.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge uart_txd);
            repeat (CPB + CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                mb[i] = uart_txd;
                if (i < 7) repeat (CPB) @(negedge clk);
            end
            tx_got.push_back(mb);
        end
    end

    initial begin
        resetn = 1'b0; CS = 1'b0; WE = 1'b0; ADDR = 2'b00; DI = 8'h00; uart_rxd = 1'b1;
        rx_ovr = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Reset state
        rd(2'b01, d); chk("reset_status", d, 8'h40);
        rd(2'b10, d); chk("reset_ctrl", d, 8'h05);
        rd(2'b11, d); chk("reset_level", d, 0);
        rd(2'b00, d); chk("reset_data_empty", d, 8'h00);
        chk("reset_irq", IRQ, 1'b0);
        chk("reset_txd", uart_txd, 1'b1);

        // Two known bytes, then random batches
        send_byte(8'h41);
        send_byte(8'h42);
        rd(2'b11, d); chk("lvl_2", d, 2);
        rd(2'b01, d); chk("stat_b3_set", d[3], 1'b1);
        chk("irq_rx", IRQ, 1'b1);
        rd(2'b00, d); chk("data_41", d, rx_q.pop_front());
        rd(2'b11, d); chk("lvl_1", d, 1);
        rd(2'b00, d); chk("data_42", d, rx_q.pop_front());
        rd(2'b11, d); chk("lvl_0", d, 0);
        rd(2'b01, d); chk("stat_b3_clr", d[3], 1'b0);
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, RX_DEPTH);
            for (int i = 0; i < n; i++) send_byte(8'($urandom));
            rd(2'b11, d); chk("rand_lvl", d, rx_q.size());
            chk("rand_irq", IRQ, rx_q.size() != 0);
            while (rx_q.size() != 0) begin
                rd(2'b00, d); chk("rand_data", d, rx_q.pop_front());
            end
            rd(2'b01, d); chk("rand_b3", d[3], 1'b0);
        end

        // Overrun
        for (int i = 0; i < RX_DEPTH + 1; i++) send_byte(8'($urandom));
        rd(2'b01, s);
        chk("ovr_b4", s[4], rx_ovr);
        chk("ovr_b5", s[5], rx_q.size() == RX_DEPTH);
        rx_ovr = 1'b0;
        rd(2'b11, d); chk("ovr_lvl", d, RX_DEPTH);
        rd(2'b01, s); chk("ovr_b4_clr", s[4], rx_ovr);
        while (rx_q.size() != 0) begin
            rd(2'b00, d); chk("ovr_data", d, rx_q.pop_front());
        end

        // TX burst: one byte leaves for the launcher while the writes stream
        // in, so DEPTH+1 of DEPTH+2 back-to-back writes are sent.
        tx_got.delete();
        txb.delete();
        for (int i = 0; i < TX_DEPTH + 2; i++) begin
            txb.push_back(8'($urandom));
            wr(2'b00, txb[i]);
        end
        rd(2'b01, s); chk("tx_full_b0", s[0], 1'b1);
        for (int k = 0; k < 3000 && tx_got.size() < TX_DEPTH + 1; k++) @(negedge clk);
        repeat (200) @(negedge clk);
        chk("tx_count", tx_got.size(), TX_DEPTH + 1);
        for (int i = 0; i < TX_DEPTH + 1 && i < tx_got.size(); i++)
            chk("tx_byte", tx_got[i], txb[i]);
        rd(2'b01, s);
        chk("tx_end_b6", s[6], 1'b1);
        chk("tx_end_b2", s[2], 1'b0);

        // Break
        uart_rxd = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("brk_irq", IRQ, 1'b1);
        rd(2'b01, s); chk("brk_b1", s[1], 1'b1);
        rd(2'b01, s); chk("brk_b1_clr", s[1], 1'b0);
        chk("brk_irq_clr", IRQ, 1'b0);

        // TX-empty interrupt, then flush of both FIFOs with a byte in flight
        wr(2'b10, 8'h02);
        rd(2'b10, d); chk("ctrl_02", d, 8'h02);
        chk("txe_irq", IRQ, 1'b1);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        tx_got.delete();
        txb.delete();
        for (int i = 0; i < 3; i++) begin
            txb.push_back(8'($urandom));
            wr(2'b00, txb[i]);
        end
        rd(2'b01, s); chk("preflush_stat", s & 8'h48, 8'h08);
        wr(2'b10, 8'hC0);
        rx_q.delete();
        rd(2'b11, d); chk("flush_rx_lvl", d, 0);
        rd(2'b01, s); chk("flush_stat", s & 8'h48, 8'h40);
        rd(2'b10, d); chk("flush_ctrl", d, 8'h00);
        chk("flush_irq", IRQ, 1'b0);
        for (int k = 0; k < 1000 && tx_got.size() < 1; k++) @(negedge clk);
        repeat (200) @(negedge clk);
        chk("flush_tx_count", tx_got.size(), 1);
        if (tx_got.size() != 0) chk("flush_tx_byte", tx_got[0], txb[0]);

        // Held read strobe pops once
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        @(negedge clk);
        CS = 1'b1; WE = 1'b0; ADDR = 2'b00;
        #1 d = DO;
        repeat (4) @(negedge clk);
        CS = 1'b0;
        chk("hold_data", d, rx_q.pop_front());
        rd(2'b11, d); chk("hold_lvl", d, rx_q.size());
        while (rx_q.size() != 0) begin
            rd(2'b00, d); chk("hold_next", d, rx_q.pop_front());
        end

        // Reset mid-transmission
        wr(2'b00, 8'($urandom));
        repeat (30) @(negedge clk);
        rd(2'b01, s); chk("midtx_active", s[2], 1'b1);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst2_txd", uart_txd, 1'b1);
        chk("rst2_irq", IRQ, 1'b0);
        rd(2'b01, d); chk("rst2_status", d, 8'h40);
        rd(2'b10, d); chk("rst2_ctrl", d, 8'h05);
        rd(2'b11, d); chk("rst2_level", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
